fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller that owns the program counter and sequences each fetch against the instruction memory with a request/ready handshake. It holds a fetched instruction until the decode stage consumes it, then applies sequential, branch or jump redirection to form the next fetch address. It replaces a free-running PC with a stall-aware, memory-latency-tolerant fetch front end and sits between instruction memory and decode.

## Interface
- RESET_PC, 32'h3000: address of the first instruction fetched after reset.
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  decode cannot accept the held instruction this cycle.
- branch_taken  input  1  consumed instruction is a taken conditional branch.
- branch_offset  input  32  signed word offset of the branch.
- jump  input  1  consumed instruction is an absolute jump.
- jump_target  input  26  jump word index.
- imem_ready  input  1  instruction memory returns imem_rdata this cycle.
- imem_rdata  input  32  instruction word.
- imem_req  output  1  fetch request, held until imem_ready.
- imem_addr  output  32  fetch address; bits [1:0] always 0.
- instr  output  32  held instruction.
- instr_valid  output  1  instr and pc_out are valid for decode.
- pc_out  output  32  address of the held instruction.
- instr_count  output  32  number of instructions consumed since reset.

## Operation
- States: BOOT, FETCH, VALID.
- Reset, asynchronous: state=BOOT, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=0, instr_valid=0, pc_out=0, instr_count=0.
- BOOT: one cycle with no request, then go to FETCH unconditionally.
- FETCH: imem_req=1, imem_addr=fetch_pc. imem_addr stays stable while waiting. On imem_ready: latch instr<=imem_rdata, pc_out<=fetch_pc, go to VALID. imem_ready outside FETCH is ignored.
- VALID: instr_valid=1, imem_req=0. If stall=1, hold everything. If stall=0 (consume): instr_count+=1 (wraps at 2^32), fetch_pc<=next_pc, go to FETCH.
- next_pc is computed only from pc_out at consume, with pc4 = pc_out+4:
  - branch_taken=1: pc4 + (branch_offset<<2), modulo 2^32 (negative offsets wrap).
  - else jump=1: {pc4[31:28], jump_target, 2'b00}.
  - else: pc4.
- branch_taken and jump both high: branch wins.
- branch_taken, jump, branch_offset and jump_target are sampled only in the consume cycle and ignored otherwise.
- At most one request is outstanding. There is no speculation, so a redirect never cancels an in-flight fetch.
- PC wrap: pc_out=32'hFFFF_FFFC sequential gives next fetch at 32'h0000_0000.
- Reset mid-handshake: request drops immediately and the sequence restarts at BOOT; the memory must tolerate an abandoned request.

## Timing
- Reset release at edge 0: BOOT during cycle 0, imem_req=1 from cycle 1.
- imem_ready in cycle N gives instr_valid=1 in cycle N+1.
- Consume (instr_valid & !stall) in cycle M gives instr_valid=0 and imem_req=1 with the new address in cycle M+1.
- Best-case throughput with zero-wait memory (ready in the same cycle as req): one instruction per 2 cycles.
- All outputs are registered except imem_addr and imem_req, which decode directly from state and fetch_pc flops (no combinational input-to-output path).

## Structure
- Shared package fetch_pkg holds:
  - the state enum (BOOT, FETCH, VALID);
  - the constants PC_STEP=4 and DEFAULT_RESET_PC=32'h3000.
- Sub-module next_pc_calc (combinational) takes pc_out, branch_taken, branch_offset, jump and jump_target and produces next_pc. It is reused later by the branch-prediction work.
- Top level is the FSM plus the fetch_pc, instr, pc_out and instr_count registers.

## Test plan
- Reset then zero-wait memory: imem_addr sequence 0x3000, 0x3004, 0x3008; instr_valid every other cycle; instr_count=3 after three consumes.
- Memory ready delayed 3 cycles at 0x3000: imem_req and imem_addr=0x3000 held stable for 3 cycles; instr_valid follows one cycle after ready.
- stall held 4 cycles in VALID: instr, pc_out and instr_count frozen; no imem_req; fetch resumes the cycle after stall drops.
- Branch at pc_out=0x3010 with offset -2: next imem_addr=0x300C. With offset +3 and jump=1 at the same time: branch wins, 0x3020.
- Jump at pc_out=0x3FFC with jump_target=26'h0000400: next imem_addr=0x0000_1000; jump at 0xF000_0000 keeps the upper nibble F.
- rst pulsed while imem_req=1: outputs return to reset values asynchronously; fetch restarts at 0x3000 with a one-cycle BOOT gap.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// fetch_pkg: shared state encoding and constants for the fetch front end.
//   state_e          : BOOT / FETCH / VALID sequencer states
//   PC_STEP          : byte distance between sequential instructions
//   DEFAULT_RESET_PC : first fetch address after reset
package fetch_pkg;
    typedef enum logic [1:0] {BOOT, FETCH, VALID} state_e;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h3000;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory request/ready handshake.
//   req   : fetch request, held until ready
//   addr  : word-aligned fetch address
//   ready : memory returns rdata this cycle
//   rdata : instruction word
interface fetch_sequencer_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;
    modport master (output req, addr, input ready, rdata);
    modport slave  (input req, addr, output ready, rdata);
endinterface

// File: rtl/fetch_sequencer_next_pc_calc.sv
// next_pc_calc: combinational next-fetch-address from the consumed instruction.
//   pc_i            : address of the consumed instruction
//   branch_taken_i  : taken conditional branch (wins over jump)
//   branch_offset_i : signed word offset relative to pc_i+4
//   jump_i          : absolute jump
//   jump_target_i   : jump word index, keeps upper nibble of pc_i+4
//   next_pc_o       : next fetch address
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_offset_i,
    input  logic        jump_i,
    input  logic [25:0] jump_target_i,
    output logic [31:0] next_pc_o
);
    logic [31:0] pc4;
    assign pc4 = pc_i + PC_STEP;
    assign next_pc_o = branch_taken_i ? pc4 + (branch_offset_i << 2)
                     : jump_i         ? {pc4[31:28], jump_target_i, 2'b00}
                     :                  pc4;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: stall-aware fetch FSM owning the program counter.
//   clk, rst        : clock, asynchronous active-high reset
//   imem            : instruction-memory handshake (master side)
//   stall_i         : decode cannot take the held instruction
//   branch_taken_i, branch_offset_i, jump_i, jump_target_i : redirect, sampled on consume
//   instr_o, pc_out_o, instr_valid_o : held instruction for decode
//   instr_count_o   : instructions consumed since reset
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    fetch_sequencer_if.master  imem,
    input  logic               stall_i,
    input  logic               branch_taken_i,
    input  logic [31:0]        branch_offset_i,
    input  logic               jump_i,
    input  logic [25:0]        jump_target_i,
    output logic [31:0]        instr_o,
    output logic               instr_valid_o,
    output logic [31:0]        pc_out_o,
    output logic [31:0]        instr_count_o
);
    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] count_q, count_d;
    logic [31:0] next_pc;

    next_pc_calc u_next_pc (
        .pc_i            (pc_out_q),
        .branch_taken_i  (branch_taken_i),
        .branch_offset_i (branch_offset_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .next_pc_o       (next_pc)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        count_d    = count_q;
        case (state_q)
            BOOT:  state_d = FETCH;
            FETCH: if (imem.ready) begin
                instr_d  = imem.rdata;
                pc_out_d = fetch_pc_q;
                state_d  = VALID;
            end
            VALID: if (!stall_i) begin
                count_d    = count_q + 32'd1;
                fetch_pc_d = next_pc;
                state_d    = FETCH;
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            instr_q    <= '0;
            pc_out_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            count_q    <= count_d;
        end
    end

    // Request and address decode straight from flops so memory sees no input-to-output path.
    assign imem.req      = (state_q == FETCH);
    assign imem.addr     = fetch_pc_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = (state_q == VALID);
    assign pc_out_o      = pc_out_q;
    assign instr_count_o = count_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed plus randomized check of fetch_sequencer against a transaction model.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [31:0] off = '0;
    logic        jmp = 1'b0;
    logic [25:0] tgt = '0;
    logic [31:0] instr, pc_out, count;
    logic        valid;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_pc, cur_pc, cnt, data;

    fetch_sequencer_if imem ();

    fetch_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .imem            (imem.master),
        .stall_i         (stall),
        .branch_taken_i  (br),
        .branch_offset_i (off),
        .jump_i          (jmp),
        .jump_target_i   (tgt),
        .instr_o         (instr),
        .instr_valid_o   (valid),
        .pc_out_o        (pc_out),
        .instr_count_o   (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] pc, input logic b, input logic [31:0] o,
                                          input logic j, input logic [25:0] t);
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (b) return seq + o * 32'd4;
        if (j) return (seq & 32'hF000_0000) | (32'(t) * 32'd4);
        return seq;
    endfunction

    function automatic logic [31:0] off_to(input logic [31:0] pc, input logic [31:0] target);
        return (target - (pc + 32'd4)) >> 2;
    endfunction

    // Entered at a negedge where a request for exp_pc is expected.
    task automatic fetch(input int lat);
        cur_pc = exp_pc;
        for (int i = 0; i < lat; i++) begin
            chk("req_wait", imem.req, 1);
            chk("addr_wait", imem.addr, exp_pc);
            imem.ready = 1'b0;
            @(negedge clk);
        end
        chk("req", imem.req, 1);
        chk("addr", imem.addr, exp_pc);
        data = $urandom;
        imem.ready = 1'b1;
        imem.rdata = data;
        @(negedge clk);
        imem.ready = 1'b0;
        chk("valid", valid, 1);
        chk("instr", instr, data);
        chk("pc_out", pc_out, cur_pc);
        chk("count_hold", count, cnt);
        chk("req_in_valid", imem.req, 0);
    endtask

    // Stall cycles drive junk on redirect and memory inputs, all of which must be ignored.
    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            stall = 1'b1;
            br = 1'($urandom);
            off = $urandom;
            jmp = 1'($urandom);
            tgt = 26'($urandom);
            imem.ready = 1'($urandom);
            imem.rdata = $urandom;
            @(negedge clk);
            chk("stall_valid", valid, 1);
            chk("stall_instr", instr, data);
            chk("stall_pc", pc_out, cur_pc);
            chk("stall_count", count, cnt);
            chk("stall_req", imem.req, 0);
        end
    endtask

    task automatic consume(input logic b, input logic [31:0] o, input logic j, input logic [25:0] t);
        stall = 1'b0;
        br = b;
        off = o;
        jmp = j;
        tgt = t;
        imem.ready = 1'b0;
        @(negedge clk);
        br = 1'b0;
        jmp = 1'b0;
        cnt = cnt + 32'd1;
        exp_pc = model(cur_pc, b, o, j, t);
        chk("cons_valid", valid, 0);
        chk("cons_req", imem.req, 1);
        chk("cons_addr", imem.addr, exp_pc);
        chk("cons_count", count, cnt);
    endtask

    initial begin
        imem.ready = 1'b0;
        imem.rdata = '0;
        cnt = '0;
        exp_pc = 32'h3000;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", imem.req, 0);
        chk("rst_addr", imem.addr, 32'h3000);
        chk("rst_valid", valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_count", count, 0);
        rst = 1'b0;
        chk("boot_gap", imem.req, 0);
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            fetch(0);
            consume(0, 0, 0, 0);
        end
        chk("seq_addr", imem.addr, 32'h300C);
        chk("three_consumed", count, 3);

        fetch(1);
        hold(4);
        consume(0, 0, 0, 0);
        fetch(0);
        consume(1, -32'sd2, 0, 0);
        chk("branch_back", imem.addr, 32'h300C);
        fetch(0);
        consume(0, 0, 0, 0);
        fetch(2);
        consume(1, 32'd3, 1, 26'h3FF_FFFF);
        chk("branch_wins", imem.addr, 32'h3020);
        fetch(0);
        consume(0, 0, 1, 26'h0000FFF);
        chk("jump_3ffc", imem.addr, 32'h3FFC);
        fetch(0);
        consume(0, 0, 1, 26'h0000400);
        chk("jump_1000", imem.addr, 32'h0000_1000);
        fetch(0);
        consume(1, off_to(32'h1000, 32'hF000_0000), 0, 0);
        chk("branch_far", imem.addr, 32'hF000_0000);
        fetch(0);
        consume(0, 0, 1, 26'h0000123);
        chk("jump_nibble_f", imem.addr, 32'hF000_048C);
        fetch(0);
        consume(1, off_to(32'hF000_048C, 32'hFFFF_FFFC), 0, 0);
        chk("to_top", imem.addr, 32'hFFFF_FFFC);
        fetch(0);
        consume(0, 0, 0, 0);
        chk("pc_wrap", imem.addr, 32'h0);

        for (int i = 0; i < 40; i++) begin
            fetch(int'($urandom_range(0, 3)));
            hold(int'($urandom_range(0, 3)));
            consume(($urandom % 4) == 0, 32'($urandom_range(0, 40)) - 32'd20,
                    ($urandom % 4) == 0, 26'($urandom));
        end

        imem.ready = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("arst_req", imem.req, 0);
        chk("arst_addr", imem.addr, 32'h3000);
        chk("arst_valid", valid, 0);
        chk("arst_instr", instr, 0);
        chk("arst_pc", pc_out, 0);
        chk("arst_count", count, 0);
        @(negedge clk);
        rst = 1'b0;
        cnt = '0;
        exp_pc = 32'h3000;
        chk("arst_boot_gap", imem.req, 0);
        @(negedge clk);
        fetch(3);
        consume(0, 0, 0, 0);
        chk("restart_addr", imem.addr, 32'h3004);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
